// File: rtl/vsync_conditioner_pkg.sv
// Shared constants, presence-state encoding and timeout helper for vsync_conditioner.
`ifndef CLK_FREQ
`define CLK_FREQ 100000000
`endif

package vsync_conditioner_pkg;

   localparam int unsigned CLK_FREQ_DEF      = `CLK_FREQ;
   localparam int unsigned FILTER_CYCLES_DEF = 16;
   localparam int unsigned TIMEOUT_MS_DEF    = 50;
   localparam int unsigned CNT_W_DEF         = 23;
   localparam int unsigned STAB_W            = 8;

   typedef enum logic [1:0] {
      ABSENT  = 2'd0,
      ARMED   = 2'd1,
      PRESENT = 2'd2
   } presence_e;

   // Watchdog limit in clock cycles for a given clock frequency and timeout in ms.
   function automatic logic [63:0] timeout_cycles(input logic [63:0] freq, input logic [63:0] ms);
      return freq * ms / 64'd1000;
   endfunction

endpackage

// File: rtl/vsync_conditioner_sync_glitch_filter.sv
// 2-FF synchroniser plus stability-counter deglitcher; filt_next_c exposes the
// level filt takes at the next edge so callers can register edge strobes.
module vsync_conditioner_sync_glitch_filter
   import vsync_conditioner_pkg::*;
#(
   parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
   input  logic clk_in,
   input  logic rst,
   input  logic din,
   output logic filt,
   output logic filt_next_c
);

   logic              sync_d;
   logic              sync_q;
   logic [STAB_W-1:0] stab_cnt;
   logic              flip_c;

   assign flip_c      = (sync_q != filt) && (stab_cnt == STAB_W'(FILTER_CYCLES - 1));
   assign filt_next_c = flip_c ? sync_q : filt;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync_d   <= 1'b0;
         sync_q   <= 1'b0;
         filt     <= 1'b0;
         stab_cnt <= '0;
      end else begin
         sync_d <= din;
         sync_q <= sync_d;
         filt   <= filt_next_c;
         if (sync_q == filt || flip_c) stab_cnt <= '0;
         else                          stab_cnt <= stab_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vsync_conditioner.sv
// VSYNC conditioner: sync + deglitch, falling-edge strobe, period measurement and
// presence watchdog. Optional polarity auto-correction under VSYNC_POLARITY_AUTO_EN.
module vsync_conditioner
   import vsync_conditioner_pkg::*;
#(
   parameter int unsigned CLK_FREQ      = CLK_FREQ_DEF,
   parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF,
   parameter int unsigned TIMEOUT_MS    = TIMEOUT_MS_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             vsync_raw,
   output logic             vsync_out,
   output logic             vsync_fall,
   output logic             sync_present,
   output logic [CNT_W-1:0] period_cycles
);

   localparam logic [63:0]      TIMEOUT_L   = timeout_cycles(64'(CLK_FREQ), 64'(TIMEOUT_MS));
   localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(TIMEOUT_L);
   localparam logic [CNT_W-1:0] TIMEOUT_M1  = TIMEOUT_CYC - CNT_W'(1);

   logic             filt;
   logic             filt_next_c;
   presence_e        state;
   logic [CNT_W-1:0] wd_cnt;
   logic             edge_c;
   logic             to_c;
   logic             vout_cur_c;
   logic             vout_next_c;
   logic             fall_ok_c;

   vsync_conditioner_sync_glitch_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clk_in      (clk_in),
      .rst         (rst),
      .din         (vsync_raw),
      .filt        (filt),
      .filt_next_c (filt_next_c)
   );

   // Timeout fires on the edge where wd_cnt reaches TIMEOUT_CYC; a coincident fall wins.
   assign to_c = (state != ABSENT) && !edge_c && (wd_cnt == TIMEOUT_M1);

`ifdef VSYNC_POLARITY_AUTO_EN
   logic             invert;
   logic             invert_next_c;
   logic             filt_fall;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] low_cnt;

   // Until lock, the watchdog follows raw filt falls so a polarity flip cannot stall it.
   assign edge_c        = (state == PRESENT) ? vsync_fall : filt_fall;
   assign invert_next_c = (edge_c && state == ARMED) ? (high_cnt > low_cnt) :
                          to_c                       ? 1'b0 : invert;
   assign vout_cur_c    = vsync_out;
   assign vout_next_c   = filt_next_c ^ invert_next_c;
   assign fall_ok_c     = (invert_next_c == invert);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         invert    <= 1'b0;
         filt_fall <= 1'b0;
         high_cnt  <= '0;
         low_cnt   <= '0;
      end else begin
         invert    <= invert_next_c;
         filt_fall <= filt & ~filt_next_c;
         if (edge_c) begin
            high_cnt <= '0;
            low_cnt  <= '0;
         end else if (filt) begin
            if (high_cnt != '1) high_cnt <= high_cnt + 1'b1;
         end else begin
            if (low_cnt != '1) low_cnt <= low_cnt + 1'b1;
         end
      end
   end
`else
   assign edge_c      = vsync_fall;
   assign vout_cur_c  = filt;
   assign vout_next_c = filt_next_c;
   assign fall_ok_c   = 1'b1;
`endif

   // Output strobes, watchdog/period counter and presence state machine.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         vsync_out     <= 1'b0;
         vsync_fall    <= 1'b0;
         sync_present  <= 1'b0;
         period_cycles <= '0;
         wd_cnt        <= '0;
         state         <= ABSENT;
      end else begin
         vsync_out  <= vout_next_c;
         vsync_fall <= vout_cur_c & ~vout_next_c & fall_ok_c;
         if (edge_c) begin
            if (state != ABSENT) begin
               period_cycles <= wd_cnt;
               state         <= PRESENT;
               sync_present  <= 1'b1;
            end else begin
               state         <= ARMED;
               sync_present  <= 1'b0;
            end
            wd_cnt <= CNT_W'(1);
         end else if (to_c) begin
            wd_cnt       <= TIMEOUT_CYC;
            state        <= ABSENT;
            sync_present <= 1'b0;
         end else if (state != ABSENT) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vsync_conditioner.sv
// Directed bench for vsync_conditioner, scaled to a 100 kHz clock so the
// 50 ms watchdog is 5000 cycles.
module tb_vsync_conditioner;

   localparam int unsigned CNT_W = 23;
   localparam int unsigned T_CYC = 5000;

   logic             clk_in = 1'b0;
   logic             rst;
   logic             vsync_raw;
   logic             vsync_out;
   logic             vsync_fall;
   logic             sync_present;
   logic [CNT_W-1:0] period_cycles;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int fall_cnt = 0;
   int last_fall_cyc = 0;
   int low_run = 0;
   int last_low_len = 0;
   int low_samples = 0;
   int width_err = 0;
   int raw_fall_cyc = 0;
   bit fall_d = 1'b0;

   vsync_conditioner #(
      .CLK_FREQ      (100000),
      .FILTER_CYCLES (16),
      .TIMEOUT_MS    (50),
      .CNT_W         (CNT_W)
   ) dut (
      .clk_in        (clk_in),
      .rst           (rst),
      .vsync_raw     (vsync_raw),
      .vsync_out     (vsync_out),
      .vsync_fall    (vsync_fall),
      .sync_present  (sync_present),
      .period_cycles (period_cycles)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc++;

   // Edge/pulse monitor sampled on the inactive edge.
   always @(negedge clk_in) begin
      if (vsync_fall) begin
         fall_cnt++;
         last_fall_cyc = cyc;
         if (fall_d) width_err++;
      end
      fall_d = vsync_fall;
      if (!vsync_out) begin
         low_run++;
         low_samples++;
      end else if (low_run > 0) begin
         last_low_len = low_run;
         low_run = 0;
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      if (obs != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic hold(input bit v, input int n);
      vsync_raw = v;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic frame(input int lo, input int per);
      vsync_raw = 1'b0;
      raw_fall_cyc = cyc;
      repeat (lo) @(posedge clk_in);
      #1 vsync_raw = 1'b1;
      repeat (per - lo) @(posedge clk_in);
      #1;
   endtask

   initial begin
      int f0;
      int ls0;
      rst = 1'b1;
      vsync_raw = 1'b1;
      repeat (3) @(negedge clk_in);
      check("rst_out", vsync_out, 0);
      check("rst_fall", vsync_fall, 0);
      check("rst_present", sync_present, 0);
      check("rst_period", period_cycles, 0);
      @(posedge clk_in);
      #1 rst = 1'b0;
      hold(1'b1, 40);
      check("idle_out_high", vsync_out, 1);
      check("idle_no_fall", fall_cnt, 0);

      // Clean 20 ms frames with 40-cycle low pulses
      frame(40, 2000);
      check("latency", last_fall_cyc - raw_fall_cyc, 18);
      check("f1_fall_cnt", fall_cnt, 1);
      check("f1_armed_only", sync_present, 0);
      check("f1_no_period", period_cycles, 0);
      frame(40, 2000);
      check("f2_present", sync_present, 1);
      check("f2_period", period_cycles, 2000);
      check("f2_low_len", last_low_len, 40);
      frame(40, 2000);
      check("f3_period", period_cycles, 2000);
      check("f3_fall_cnt", fall_cnt, 3);

      // Glitches of 1..15 cycles on the high level must vanish
      f0 = fall_cnt;
      ls0 = low_samples;
      for (int g = 1; g <= 15; g++) begin
         hold(1'b0, g);
         hold(1'b1, 20);
      end
      check("glitch_no_fall", fall_cnt - f0, 0);
      check("glitch_no_low", low_samples - ls0, 0);

      // A 16-cycle glitch passes as a single 16-cycle low pulse
      hold(1'b0, 16);
      hold(1'b1, 1652);
      check("g16_one_fall", fall_cnt - f0, 1);
      check("g16_low_len", last_low_len, 16);
      check("g16_period", period_cycles, 2420);

      // NTSC-like periods of 1668/1669 cycles
      frame(40, 1668);
      check("ntsc_period_a", period_cycles, 1668);
      frame(40, 1669);
      frame(40, 1668);
      check("ntsc_period_c", period_cycles, 1669);

      // Stop toggling: presence drops exactly T_CYC cycles after the last fall
      for (int i = 0; i < 6000 && sync_present; i++) @(negedge clk_in);
      check("to_present", sync_present, 0);
      check("to_time", cyc - last_fall_cyc, T_CYC);
      check("to_period_held", period_cycles, 1669);
      @(posedge clk_in);
      #1;
      frame(40, 2000);
      check("re_armed_only", sync_present, 0);
      check("re_period_held", period_cycles, 1669);
      frame(40, 2000);
      check("re_present", sync_present, 1);
      check("re_period", period_cycles, 2000);

      // Asynchronous reset in the middle of the high level
      hold(1'b1, 500);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out", vsync_out, 0);
      check("mid_rst_fall", vsync_fall, 0);
      check("mid_rst_present", sync_present, 0);
      check("mid_rst_period", period_cycles, 0);
      @(posedge clk_in);
      #1 rst = 1'b0;
      hold(1'b1, 40);
      f0 = fall_cnt;
      frame(40, 2000);
      check("post_rst_fall", fall_cnt - f0, 1);
      check("post_rst_armed", sync_present, 0);
      check("post_rst_period", period_cycles, 0);
      frame(40, 2000);
      check("post_rst_present", sync_present, 1);
      check("post_rst_period2", period_cycles, 2000);
      check("fall_width", width_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
